// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants and helpers for the pipelined add/subtract unit.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   chunk_width()          : bits resolved per pipeline stage
//   widths_ok()            : configuration legality (STAGES must divide WIDTH)
//   stage_rec_t            : record carried by one pipeline stage (default size)
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit widths_ok(input int width, input int stages);
    return (width > 0) && (stages > 0) && ((width % stages) == 0);
  endfunction

  localparam int DEF_CHUNK  = chunk_width(DEF_WIDTH, DEF_STAGES);
  localparam bit DEF_CFG_OK = widths_ok(DEF_WIDTH, DEF_STAGES);

  // Contents of one stage at the default size. The top keeps the same fields
  // per stage, but narrows a_hi/b_hi and widens s_lo as chunks are consumed,
  // so no stage stores bits that nothing downstream reads.
  typedef struct packed {
    logic                 valid;
    logic                 sub;
    logic                 carry;   // raw carry out of the chunk just resolved
    logic [DEF_WIDTH-1:0] a_hi;    // operand A bits not yet consumed
    logic [DEF_WIDTH-1:0] b_hi;    // effective operand B bits not yet consumed
    logic [DEF_WIDTH-1:0] s_lo;    // result bits already resolved
  } stage_rec_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// -----------------------------------------------------------------------------
// pipe_adder_slice
// CHUNK-bit combinational ripple-carry adder built from full-adder cells.
//   a_i, b_i  : chunk operands (b_i already inverted for subtract)
//   c_i       : carry into bit 0 of the chunk
//   s_o       : chunk sum
//   c_o       : carry out of the chunk MSB
//   c_msb_o   : carry into the chunk MSB (signed-overflow detection)
// -----------------------------------------------------------------------------
module pipe_adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c;

  assign c[0] = c_i;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s_o[gi]  = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]  = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign c_o     = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Pipelined ripple-carry add/subtract unit with valid/ready on both sides.
// Stage k resolves one CHUNK-bit slice of the carry chain; the operand bits
// still to be added ride along in shrinking skew registers while the resolved
// result bits accumulate below them.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   a, b, cin, sub      : operands, carry/borrow-in, mode (1 = a - b - cin)
//   out_valid/out_ready : output handshake
//   s, cout, ovf        : result, carry/borrow-out, signed overflow
//   busy                : any stage holds a valid transaction
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!widths_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_adder: STAGES must evenly divide WIDTH");
  end

  // The whole pipe moves as one; it only stops when a finished result is
  // waiting at the output and nobody takes it.
  logic              en;
  logic [STAGES-1:0] valid_vec;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign busy     = |valid_vec;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int IN_W = WIDTH - gi * CHUNK;  // unconsumed operand bits entering
    localparam int LO   = (gi + 1) * CHUNK;    // result bits complete after stage
    localparam int HI   = WIDTH - LO;          // operand bits left after stage

    logic             valid_q;
    logic             sub_q;
    logic             carry_q;
    logic [LO-1:0]    s_lo_q, s_lo_d;

    logic [IN_W-1:0]  in_a, in_b;
    logic             in_c, in_sub, in_v;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co, chunk_cmsb;

    if (gi == 0) begin : g_first
      // Subtract as a + ~b + ~cin; the inverted B is what travels down the pipe.
      assign in_a   = a;
      assign in_b   = sub ? ~b : b;
      assign in_c   = cin ^ sub;
      assign in_sub = sub;
      assign in_v   = in_valid;
      assign s_lo_d = chunk_s;
    end else begin : g_next
      assign in_a   = g_stage[gi-1].g_skew.a_hi_q;
      assign in_b   = g_stage[gi-1].g_skew.b_hi_q;
      assign in_c   = g_stage[gi-1].carry_q;
      assign in_sub = g_stage[gi-1].sub_q;
      assign in_v   = g_stage[gi-1].valid_q;
      assign s_lo_d = {chunk_s, g_stage[gi-1].s_lo_q};
    end

    pipe_adder_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a_i    (in_a[CHUNK-1:0]),
      .b_i    (in_b[CHUNK-1:0]),
      .c_i    (in_c),
      .s_o    (chunk_s),
      .c_o    (chunk_co),
      .c_msb_o(chunk_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        sub_q   <= 1'b0;
        carry_q <= 1'b0;
        s_lo_q  <= '0;
      end else if (en) begin
        valid_q <= in_v;
        sub_q   <= in_sub;
        carry_q <= chunk_co;
        s_lo_q  <= s_lo_d;
      end
    end

    if (HI > 0) begin : g_skew
      logic [HI-1:0] a_hi_q, b_hi_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en) begin
          a_hi_q <= in_a[IN_W-1:CHUNK];
          b_hi_q <= in_b[IN_W-1:CHUNK];
        end
      end
    end

    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_q, ovf_d;

      // Overflow uses raw carries, so it is correct for subtract as well.
      assign ovf_d = chunk_cmsb ^ chunk_co;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end

    assign valid_vec[gi] = valid_q;
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].s_lo_q;
  // In subtract mode the borrow is the complement of the raw carry.
  assign cout      = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].sub_q;
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Directed and randomised-stall checks of pipe_adder at WIDTH=16, STAGES=4.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b, s;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];  // {cout, ovf, s}

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic for the random soak: {carry/borrow, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic m);
    logic [16:0] r;
    logic        v;
    if (!m) begin
      r = {1'b0, x} + {1'b0, y} + 17'(c);
      v = (x[15] == y[15]) && (r[15] != x[15]);
    end else begin
      r = {1'b0, x} - {1'b0, y} - 17'(c);
      v = (x[15] != y[15]) && (r[15] != x[15]);
    end
    return {r[16], v, r[15:0]};
  endfunction

  task automatic drive(input logic [15:0] ta, input logic [15:0] tbv,
                       input logic tc, input logic ts, input logic tv);
    a        = ta;
    b        = tbv;
    cin      = tc;
    sub      = ts;
    in_valid = tv;
  endtask

  // Present one transaction for one edge, then return to idle.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tbv,
                       input logic tc, input logic ts);
    drive(ta, tbv, tc, ts, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (s !== 16'h0000) begin n_err++; $display("FAIL rst_s: got %h want 0000", s); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_carry_chain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_early: got out_valid %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL carry_busy: got %b want 1", busy); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL carry_valid: got %b want 1", out_valid); end
    n_vec++; if (s !== 16'h0000) begin n_err++; $display("FAIL carry_s: got %h want 0000", s); end
    n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry_cout: got %b want 1", cout); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL carry_ovf: got %b want 0", ovf); end
    $display("carry: FFFF+0001 -> s=%h cout=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_single: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf1_valid: got %b want 1", out_valid); end
    n_vec++; if (s !== 16'h8000) begin n_err++; $display("FAIL ovf1_s: got %h want 8000", s); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL ovf1_cout: got %b want 0", cout); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf1_ovf: got %b want 1", ovf); end
    $display("overflow: 7FFF+0001 -> s=%h cout=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf2_valid: got %b want 1", out_valid); end
    n_vec++; if (s !== 16'h7FFF) begin n_err++; $display("FAIL ovf2_s: got %h want 7fff", s); end
    n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL ovf2_cout: got %b want 1", cout); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf2_ovf: got %b want 1", ovf); end
    $display("overflow: 8000+FFFF -> s=%h cout=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
  endtask

  task automatic test_subtract();
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_vec++; if (s !== 16'hFFFE) begin n_err++; $display("FAIL sub1_s: got %h want fffe", s); end
    n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub1_borrow: got %b want 1", cout); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL sub1_ovf: got %b want 0", ovf); end
    $display("subtract: 0005-0007-0 -> s=%h borrow=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
    issue(16'h0007, 16'h0005, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    n_vec++; if (s !== 16'h0001) begin n_err++; $display("FAIL sub2_s: got %h want 0001", s); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL sub2_borrow: got %b want 0", cout); end
    $display("subtract: 0007-0005-1 -> s=%h borrow=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (s !== 16'h5556) begin n_err++; $display("FAIL addc_s: got %h want 5556", s); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL addc_cout: got %b want 0", cout); end
    $display("add: 1234+4321+1 -> s=%h cout=%b ovf=%b", s, cout, ovf);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s [8];
    int          k;
    logic        want_v;
    exp_s = '{16'h0000, 16'h1001, 16'h2002, 16'h3003,
              16'h4004, 16'h5005, 16'h6006, 16'h7007};
    out_ready = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      k      = cyc - 4;
      want_v = (k >= 0) && (k < 8);
      n_vec++; if (out_valid !== want_v) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want %b", cyc, out_valid, want_v); end
      if (want_v) begin
        n_vec++; if (s !== exp_s[k]) begin n_err++; $display("FAIL stream_s[%0d]: got %h want %h", k, s, exp_s[k]); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL stream_cout[%0d]: got %b want 0", k, cout); end
        $display("stream: result %0d s=%h", k, s);
      end
      if (cyc < 8) drive(16'(cyc), 16'(cyc) << 12, 1'b0, 1'b0, 1'b1);
      else         in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ta [6];
    logic [17:0] e;
    int          sent = 0;
    int          got  = 0;
    ta = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    exp_q.delete();
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = (c >= 7);
      if (sent < 6) drive(ta[sent], 16'h0101, 1'b0, 1'b0, 1'b1);
      else          in_valid = 1'b0;
      #1;
      if (c >= 4 && c <= 6) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
        n_vec++; if (s !== 16'h1212) begin n_err++; $display("FAIL stall_s[%0d]: got %h want 1212", c, s); end
        n_vec++; if (cout !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL stall_flags[%0d]: got %b%b want 00", c, cout, ovf); end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got s=%h want no output", s);
        end else begin
          e = exp_q.pop_front();
          if ({cout, ovf, s} !== e) begin n_err++; $display("FAIL bp_result[%0d]: got %h want %h", got, {cout, ovf, s}, e); end
          $display("backpressure: result %0d s=%h", got, s);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({2'b00, ta[sent] + 16'h0101});
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++; if (got != 6) begin n_err++; $display("FAIL bp_count: got %0d results want 6", got); end
    repeat (5) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: got out_valid %b want 0", out_valid); end
    end
  endtask

  task automatic test_soak();
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] e;
    int          sent = 0;
    int          got  = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 150 && $urandom_range(0, 4) != 0) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        drive(ra, rb, rc, rs, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL soak_extra: got s=%h want no output", s);
        end else begin
          e = exp_q.pop_front();
          if ({cout, ovf, s} !== e) begin n_err++; $display("FAIL soak_result[%0d]: got %h want %h", got, {cout, ovf, s}, e); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ra, rb, rc, rs));
        sent++;
      end
      if (sent == 150 && got == sent) break;
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (got != 150) begin n_err++; $display("FAIL soak_count: got %0d results want 150", got); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL soak_drain_busy: got %b want 0", busy); end
    $display("soak: %0d random transactions compared under random stalls", got);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(16'(k) << 8, 16'h0001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    n_vec++; if (s !== 16'h0101) begin n_err++; $display("FAIL mid_pre_s: got %h want 0101", s); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_vec++; if (s !== 16'h0000) begin n_err++; $display("FAIL mid_rst_s: got %h want 0000", s); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: got out_valid %b want 0", c, out_valid); end
    end
    issue(16'h0003, 16'h0004, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_new_valid: got %b want 1", out_valid); end
    n_vec++; if (s !== 16'h0007) begin n_err++; $display("FAIL mid_new_s: got %h want 0007", s); end
    $display("reset mid-flight: new transaction s=%h", s);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_new_single: got out_valid %b want 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_soak();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
